// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arbiter
//  Description : Round-robin arbiter granting NREQ requesters shared access
//                to a single registered adder. A grant latches operands and
//                requester id, the sum is computed in the following cycle,
//                and the result is then offered with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH:0]           rsp_sum,
    output logic                     busy,
    output logic [15:0]              op_count
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;
    logic [IDW-1:0]   id_q,        id_d;
    logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH:0]   sum_q,       sum_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      op_count_q,  op_count_d;

    logic [WIDTH-1:0] w_a_arr [NREQ];
    logic [WIDTH-1:0] w_b_arr [NREQ];
    logic             w_win_found;
    logic [IDW-1:0]   w_win_idx;
    logic [IDW-1:0]   w_cand;

    // Split the packed operand buses into per-requester lanes
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
        assign w_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end

    // Round-robin search: first valid requester at or after ptr, wrapping
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            // NREQ is a power of two, so the index addition wraps naturally
            w_cand = ptr_q + IDW'(k);
            if (!w_win_found && req_valid[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    // One-hot accept, only in IDLE and never while reset is held low
    always_comb begin
        req_ready = '0;
        if (reset && (state_q == ST_IDLE) && w_win_found) begin
            req_ready[w_win_idx] = 1'b1;
        end
    end

    // Next-state and datapath update for the IDLE/COMPUTE/RESPOND sequence
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (w_win_found) begin
                    a_d     = w_a_arr[w_win_idx];
                    b_d     = w_b_arr[w_win_idx];
                    id_d    = w_win_idx;
                    ptr_d   = w_win_idx + IDW'(1);
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                // Result outputs change only here so they hold while idle
                sum_d       = {1'b0, a_q} + {1'b0, b_q};
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESPOND;
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            rsp_id_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = sum_q;
    assign busy      = (state_q != ST_IDLE);
    assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_arbiter
//  Description : Self-checking bench for adder_arbiter with a behavioural
//                round-robin / adder reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [WIDTH:0]        rsp_sum;
    logic                  busy;
    logic [15:0]           op_count;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_ptr;
    logic [15:0] m_count;
    logic [1:0]  m_last_id;
    logic [8:0]  m_last_sum;
    int          ma [NREQ];
    int          mb [NREQ];

    adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int predict_winner(input logic [NREQ-1:0] v);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr      = 0;
        m_count    = 16'd0;
        m_last_id  = 2'd0;
        m_last_sum = 9'd0;
    endtask

    task automatic load_operands();
        for (int i = 0; i < NREQ; i++) begin
            ma[i] = int'($urandom_range(0, 255));
            mb[i] = int'($urandom_range(0, 255));
            req_a[i*WIDTH +: WIDTH] = 8'(ma[i]);
            req_b[i*WIDTH +: WIDTH] = 8'(mb[i]);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_a     = $urandom;
        req_b     = $urandom;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_sum !== 9'd0) begin failures++; $display("FAIL reset_rsp_sum got=%h exp=000", rsp_sum); end
        checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        model_reset();
    endtask

    // single request and carry case on fixed operands
    task automatic test_directed();
        int         idx_t [2] = '{0, 2};
        logic [7:0] a_t   [2] = '{8'h0F, 8'hFF};
        logic [7:0] b_t   [2] = '{8'h01, 8'hFF};
        logic [8:0] s_t   [2] = '{9'h010, 9'h1FE};
        int idx;
        for (int t = 0; t < 2; t++) begin
            idx = idx_t[t];
            @(negedge clk);
            req_a = $urandom;
            req_b = $urandom;
            req_a[idx*WIDTH +: WIDTH] = a_t[t];
            req_b[idx*WIDTH +: WIDTH] = b_t[t];
            req_valid = onehot(idx);
            rsp_ready = 1'b1;
            #1;
            checks++; if (req_ready !== onehot(idx)) begin failures++; $display("FAIL dir_grant t=%0d got=%b exp=%b", t, req_ready, onehot(idx)); end
            m_ptr = (idx + 1) % NREQ;
            @(negedge clk);
            req_valid = '0;
            req_a = $urandom;
            req_b = $urandom;
            #1;
            checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || rsp_sum !== m_last_sum) begin
                failures++; $display("FAIL dir_compute t=%0d busy=%b valid=%b sum=%h exp busy=1 valid=0 sum=%h", t, busy, rsp_valid, rsp_sum, m_last_sum);
            end
            @(negedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(idx) || rsp_sum !== s_t[t]) begin
                failures++; $display("FAIL dir_respond t=%0d valid=%b id=%0d sum=%h exp valid=1 id=%0d sum=%h", t, rsp_valid, rsp_id, rsp_sum, idx, s_t[t]);
            end
            m_last_id  = 2'(idx);
            m_last_sum = s_t[t];
            m_count    = m_count + 16'd1;
            @(negedge clk); #1;
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== m_count) begin
                failures++; $display("FAIL dir_done t=%0d valid=%b busy=%b count=%0d exp valid=0 busy=0 count=%0d", t, rsp_valid, busy, op_count, m_count);
            end
        end
    endtask

    task automatic test_backpressure();
        int         idx;
        logic [8:0] exp_sum;
        @(negedge clk);
        idx = int'($urandom_range(0, NREQ-1));
        load_operands();
        req_valid = onehot(idx);
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== onehot(idx)) begin failures++; $display("FAIL bp_grant got=%b exp=%b", req_ready, onehot(idx)); end
        exp_sum = 9'(ma[idx] + mb[idx]);
        m_ptr   = (idx + 1) % NREQ;
        @(negedge clk);
        req_valid = 4'b1111;
        req_a = $urandom;
        req_b = $urandom;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_compute_ready got=%b exp=0000", req_ready); end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(idx) || rsp_sum !== exp_sum || req_ready !== 4'b0000 || busy !== 1'b1 || op_count !== m_count) begin
                failures++;
                $display("FAIL bp_hold c=%0d valid=%b id=%0d sum=%h ready=%b busy=%b count=%0d exp 1/%0d/%h/0000/1/%0d",
                         c, rsp_valid, rsp_id, rsp_sum, req_ready, busy, op_count, idx, exp_sum, m_count);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%b exp=1", rsp_valid); end
        m_last_id  = 2'(idx);
        m_last_sum = exp_sum;
        m_count    = m_count + 16'd1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || op_count !== m_count) begin
            failures++; $display("FAIL bp_done valid=%b count=%0d exp valid=0 count=%0d", rsp_valid, op_count, m_count);
        end
        @(negedge clk); #1;
        checks++; if (op_count !== m_count || rsp_sum !== m_last_sum || rsp_id !== m_last_id) begin
            failures++; $display("FAIL bp_once count=%0d sum=%h id=%0d exp count=%0d sum=%h id=%0d", op_count, rsp_sum, rsp_id, m_count, m_last_sum, m_last_id);
        end
    endtask

    task automatic test_reset_midflight();
        logic [8:0] exp_sum;
        @(negedge clk);
        load_operands();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_grant got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_in_compute busy=%b exp=1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 9'd0 || op_count !== 16'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            failures++; $display("FAIL mid_async valid=%b id=%0d sum=%h count=%0d busy=%b ready=%b exp all zero", rsp_valid, rsp_id, rsp_sum, op_count, busy, req_ready);
        end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_no_response valid=%b count=%0d busy=%b exp 0/0/0", rsp_valid, op_count, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        load_operands();
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr_cleared got=%b exp=0001", req_ready); end
        exp_sum = 9'(ma[0] + mb[0]);
        m_ptr   = 1;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== exp_sum) begin
            failures++; $display("FAIL mid_after valid=%b id=%0d sum=%h exp 1/0/%h", rsp_valid, rsp_id, rsp_sum, exp_sum);
        end
        m_last_id  = 2'd0;
        m_last_sum = exp_sum;
        m_count    = 16'd1;
        @(negedge clk); #1;
        checks++; if (op_count !== m_count) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", op_count, m_count); end
    endtask

    task automatic test_fairness();
        int         g;
        logic [8:0] exp_sum;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < NREQ; i++) begin
            ma[i] = 17 + 65 * i;
            mb[i] = int'($urandom_range(0, 255));
            req_a[i*WIDTH +: WIDTH] = 8'(ma[i]);
            req_b[i*WIDTH +: WIDTH] = 8'(mb[i]);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            #1;
            g = predict_winner(req_valid);
            checks++; if (req_ready !== onehot(g) || op_count !== m_count) begin
                failures++; $display("FAIL fair_grant t=%0d ready=%b count=%0d exp ready=%b count=%0d", t, req_ready, op_count, onehot(g), m_count);
            end
            m_ptr   = (g + 1) % NREQ;
            exp_sum = 9'(ma[g] + mb[g]);
            @(negedge clk); #1;
            checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
                failures++; $display("FAIL fair_compute t=%0d ready=%b valid=%b exp 0000/0", t, req_ready, rsp_valid);
            end
            @(negedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_sum !== exp_sum) begin
                failures++; $display("FAIL fair_respond t=%0d valid=%b id=%0d sum=%h exp 1/%0d/%h", t, rsp_valid, rsp_id, rsp_sum, g, exp_sum);
            end
            m_last_id  = 2'(g);
            m_last_sum = exp_sum;
            m_count    = m_count + 16'd1;
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        checks++; if (op_count !== m_count || busy !== 1'b0) begin
            failures++; $display("FAIL fair_end count=%0d busy=%b exp %0d/0", op_count, busy, m_count);
        end
    endtask

    task automatic test_random();
        int              g;
        int              stall;
        logic [NREQ-1:0] v;
        logic [8:0]      exp_sum;
        @(negedge clk);
        for (int it = 0; it < 40; it++) begin
            v = 4'($urandom_range(0, 15));
            load_operands();
            req_valid = v;
            rsp_ready = 1'b0;
            #1;
            g = predict_winner(v);
            if (g < 0) begin
                checks++; if (req_ready !== 4'b0000 || busy !== 1'b0 || rsp_sum !== m_last_sum) begin
                    failures++; $display("FAIL rnd_idle it=%0d ready=%b busy=%b sum=%h exp 0000/0/%h", it, req_ready, busy, rsp_sum, m_last_sum);
                end
                @(negedge clk);
                continue;
            end
            checks++; if (req_ready !== onehot(g) || op_count !== m_count || rsp_valid !== 1'b0) begin
                failures++; $display("FAIL rnd_grant it=%0d ready=%b count=%0d valid=%b exp %b/%0d/0", it, req_ready, op_count, rsp_valid, onehot(g), m_count);
            end
            m_ptr   = (g + 1) % NREQ;
            exp_sum = 9'(ma[g] + mb[g]);
            @(negedge clk);
            req_a = $urandom;
            req_b = $urandom;
            #1;
            checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || rsp_sum !== m_last_sum || rsp_id !== m_last_id || req_ready !== 4'b0000) begin
                failures++; $display("FAIL rnd_compute it=%0d busy=%b valid=%b sum=%h id=%0d ready=%b exp 1/0/%h/%0d/0000",
                                     it, busy, rsp_valid, rsp_sum, rsp_id, req_ready, m_last_sum, m_last_id);
            end
            @(negedge clk);
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                #1;
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_sum !== exp_sum || req_ready !== 4'b0000) begin
                    failures++; $display("FAIL rnd_stall it=%0d valid=%b id=%0d sum=%h ready=%b exp 1/%0d/%h/0000", it, rsp_valid, rsp_id, rsp_sum, req_ready, g, exp_sum);
                end
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_sum !== exp_sum) begin
                failures++; $display("FAIL rnd_respond it=%0d valid=%b id=%0d sum=%h exp 1/%0d/%h", it, rsp_valid, rsp_id, rsp_sum, g, exp_sum);
            end
            m_last_id  = 2'(g);
            m_last_sum = exp_sum;
            m_count    = m_count + 16'd1;
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            checks++; if (rsp_valid !== 1'b0 || op_count !== m_count) begin
                failures++; $display("FAIL rnd_done it=%0d valid=%b count=%0d exp 0/%0d", it, rsp_valid, op_count, m_count);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        int g;
        @(negedge clk);
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        m_count = 16'hFFFE;
        for (int t = 0; t < 2; t++) begin
            g = int'($urandom_range(0, NREQ-1));
            load_operands();
            req_valid = onehot(g);
            rsp_ready = 1'b1;
            #1;
            checks++; if (req_ready !== onehot(g)) begin failures++; $display("FAIL wrap_grant t=%0d got=%b exp=%b", t, req_ready, onehot(g)); end
            m_ptr = (g + 1) % NREQ;
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            @(negedge clk); #1;
            m_count = m_count + 16'd1;
            checks++; if (op_count !== m_count) begin failures++; $display("FAIL wrap_count t=%0d got=%h exp=%h", t, op_count, m_count); end
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_fairness();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
